// File: rtl/ins_loader.sv
// ins_loader: assembles a byte stream into 16-bit words, writes them to instruction memory and holds the CPU until the load is verified
module ins_loader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int BASE   = 0,
  parameter int STEP   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_byte,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);
  typedef enum logic [2:0] {IDLE, LEN, HI, LO, WRITE, CSUM, DONE, ERR} state_t;
  state_t state, nxt;
  logic [7:0] len, cnt, hi, csum;
  logic xfer, last;
  assign xfer     = in_valid & in_ready;
  assign last     = (cnt + 8'd1) == len;
  assign wr_en    = state == WRITE;
  assign cpu_hold = state != DONE;
  assign done     = state == DONE;
  assign err      = state == ERR;
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  // next-state and ready decode; start only honoured between loads
  always_comb begin
    nxt      = state;
    in_ready = state inside {LEN, HI, LO, CSUM};
    case (state)
      IDLE, DONE, ERR: nxt = start ? LEN : state;
      LEN:   nxt = xfer ? (in_byte == 8'd0 ? CSUM : HI) : state;
      HI:    nxt = xfer ? LO : state;
      LO:    nxt = xfer ? WRITE : state;
      WRITE: nxt = last ? CSUM : HI;
      CSUM:  nxt = xfer ? (in_byte == csum ? DONE : ERR) : state;
      default: nxt = IDLE;
    endcase
  end
  // datapath: length, word assembly, running checksum, write address/count
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      len     <= '0;
      cnt     <= '0;
      hi      <= '0;
      csum    <= '0;
      wr_addr <= ADDR_W'(BASE);
      wr_data <= '0;
    end else begin
      case (state)
        IDLE, DONE, ERR:
          if (start) begin
            csum    <= '0;
            cnt     <= '0;
            wr_addr <= ADDR_W'(BASE);
          end
        LEN:
          if (xfer) len <= in_byte;
        HI:
          if (xfer) begin
            hi   <= in_byte;
            csum <= csum ^ in_byte;
          end
        LO:
          if (xfer) begin
            wr_data <= DATA_W'({hi, in_byte});
            csum    <= csum ^ in_byte;
          end
        WRITE: begin
          wr_addr <= wr_addr + ADDR_W'(STEP);
          cnt     <= cnt + 8'd1;
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_ins_loader.sv
// tb_ins_loader: directed checks of ins_loader stream loading, checksum, wrap and reset
module tb_ins_loader;
  logic clk = 0, rst_n = 0, start = 0, in_valid = 0;
  logic [7:0] in_byte = 0;
  logic in_ready0, wr_en0, cpu_hold0, done0, err0;
  logic in_ready1, wr_en1, cpu_hold1, done1, err1;
  logic [7:0] wr_addr0, wr_addr1;
  logic [15:0] wr_data0, wr_data1;
  int total = 0, bad = 0;
  logic gate_start = 0;
  logic [7:0] wa0[$], wa1[$];
  logic [15:0] wd0[$], wd1[$];
  logic [7:0] s[$];

  always #5 clk = ~clk;

  ins_loader #(.BASE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_byte(in_byte),
    .in_ready(in_ready0), .wr_en(wr_en0), .wr_addr(wr_addr0), .wr_data(wr_data0),
    .cpu_hold(cpu_hold0), .done(done0), .err(err0));

  ins_loader #(.BASE(8'hFE)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_byte(in_byte),
    .in_ready(in_ready1), .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1),
    .cpu_hold(cpu_hold1), .done(done1), .err(err1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // record every write strobe cycle; ready must be low while writing
  always @(negedge clk) begin
    if (wr_en0) begin
      wa0.push_back(wr_addr0);
      wd0.push_back(wr_data0);
      chk("ready_in_write", {31'b0, in_ready0}, 32'd0);
    end
    if (wr_en1) begin
      wa1.push_back(wr_addr1);
      wd1.push_back(wr_data1);
    end
  end

  task automatic send(input logic [7:0] b, input int gap);
    int n = 0;
    for (int i = 0; i < gap; i++) begin
      in_valid = 0;
      start = gate_start;
      @(negedge clk);
    end
    start = 0;
    in_valid = 1;
    in_byte = b;
    while (!in_ready0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("ready_timeout", n, 0);
    @(negedge clk);
    in_valid = 0;
  endtask

  task automatic pulse_start;
    start = 1;
    @(negedge clk);
    start = 0;
  endtask

  task automatic load(input int maxgap);
    wa0.delete(); wd0.delete(); wa1.delete(); wd1.delete();
    pulse_start();
    foreach (s[i]) send(s[i], maxgap > 0 ? int'($urandom_range(1, maxgap)) : 0);
    @(negedge clk);
  endtask

  task automatic chk_two_words(input string tag);
    chk({tag, "_nwr"}, wa0.size(), 2);
    chk({tag, "_a0"}, wa0[0], 8'h00);
    chk({tag, "_d0"}, wd0[0], 16'h1234);
    chk({tag, "_a1"}, wa0[1], 8'h02);
    chk({tag, "_d1"}, wd0[1], 16'hABCD);
  endtask

  task automatic chk_status(input string tag, input logic d, input logic e, input logic h);
    chk({tag, "_done"}, done0, d);
    chk({tag, "_err"}, err0, e);
    chk({tag, "_hold"}, cpu_hold0, h);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    chk("rst_ready", in_ready0, 0);
    chk("rst_wren", wr_en0, 0);
    chk("rst_addr", wr_addr0, 8'h00);
    chk("rst_addr_fe", wr_addr1, 8'hFE);
    chk("rst_data", wr_data0, 0);
    chk_status("rst", 0, 0, 1);
    rst_n = 1;
    @(negedge clk);
    chk("idle_ready", in_ready0, 0);

    s = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
    load(0);
    chk_two_words("good");
    chk_status("good", 1, 0, 0);

    s = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h41};
    load(0);
    chk_two_words("bad");
    chk_status("bad", 0, 1, 1);
    s = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
    load(0);
    chk_two_words("recov");
    chk_status("recov", 1, 0, 0);

    s = '{8'h00, 8'h00};
    load(0);
    chk("l0_nwr", wa0.size(), 0);
    chk_status("l0_ok", 1, 0, 0);
    s = '{8'h00, 8'h01};
    load(0);
    chk("l0b_nwr", wa0.size(), 0);
    chk_status("l0_bad", 0, 1, 1);

    gate_start = 1;
    s = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
    load(3);
    gate_start = 0;
    chk_two_words("stall");
    chk_status("stall", 1, 0, 0);

    s = '{8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
    load(0);
    chk("wrap_nwr", wa1.size(), 2);
    chk("wrap_a0", wa1[0], 8'hFE);
    chk("wrap_d0", wd1[0], 16'h1122);
    chk("wrap_a1", wa1[1], 8'h00);
    chk("wrap_d1", wd1[1], 16'h3344);
    chk("wrap_done", done1, 1);

    wa1.delete(); wd1.delete();
    pulse_start();
    send(8'h02, 0);
    send(8'h55, 0);
    send(8'h66, 0);
    @(negedge clk);
    chk("clr_nwr_pre", wa1.size(), 1);
    chk("clr_a0", wa1[0], 8'hFE);
    chk("clr_d0", wd1[0], 16'h5566);
    rst_n = 0;
    #1;
    chk("clr_ready", in_ready1, 0);
    chk("clr_wren", wr_en1, 0);
    chk("clr_hold", cpu_hold1, 1);
    chk("clr_done", done1, 0);
    chk("clr_err", err1, 0);
    chk("clr_addr", wr_addr1, 8'hFE);
    chk("clr_data", wr_data1, 0);
    @(negedge clk);
    rst_n = 1;
    in_valid = 1;
    in_byte = 8'h77;
    repeat (6) @(negedge clk);
    in_valid = 0;
    chk("clr_nwr_post", wa1.size(), 1);
    chk("clr_hold_post", cpu_hold1, 1);
    chk("clr_ready_post", in_ready1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
